clk_divider_multi: RTL and testbench

- Parametrised, multi-channel successor to the fixed 100 MHz→1 kHz divider.
- Generates NUM_CH independent square-wave clocks from clk_fpga, each with a run-time programmable half-period.
- Each channel also produces a single-cycle clock-enable tick for synchronous consumers, such as display refresh, debounce, game timer and score blink, so downstream logic can stay on clk_fpga.
- Divisor updates are glitch-free: they take effect only at a half-period boundary.

---
 rtl/clk_divider_multi.sv | 108 ++++++++++
 tb/tb_clk_divider_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH independent programmable square-wave dividers.
// Each channel counts clk_fpga cycles up to its half-period, toggles its
// clk_out at every half-period boundary and emits a one-cycle tick on the
// rising toggle. New half-periods are staged in a pending register and only
// take effect at a boundary, so the output never glitches mid-phase.
module clk_divider_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 27,
  parameter int DEF_HALF = 50_000,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_fpga,
  input  logic              rst_n,
  input  logic              en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // Out-of-range selects (possible when NUM_CH is not a power of two) are dropped.
  logic sel_ok;
  assign sel_ok = ({1'b0, div_sel} < (SEL_W + 1)'(NUM_CH));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             wr_hit;

    assign wr_hit = div_wr && sel_ok && (div_sel == SEL_W'(gi));

    // Next-state: count, toggle at boundary, stage/apply divisor writes.
    always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      pend_d = pend_q;
      clk_d  = clk_q;
      busy_d = busy_q;
      tick_d = 1'b0;
      if (half_q == '0) begin
        // Stopped: no boundary will ever come, so a write restarts at once.
        cnt_d = '0;
        clk_d = 1'b0;
        if (wr_hit) begin
          half_d = div_val;
          pend_d = div_val;
          busy_d = 1'b0;
        end
      end else begin
        if (en) begin
          if (cnt_q == half_q - ONE) begin
            cnt_d  = '0;
            half_d = pend_q;
            busy_d = 1'b0;
            if (pend_q == '0) begin
              // Switching to stopped: park the output low.
              clk_d = 1'b0;
            end else begin
              clk_d  = ~clk_q;
              tick_d = ~clk_q;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        // A write coinciding with a boundary lands in pend after the
        // boundary consumed the old value, so it waits for the next one.
        if (wr_hit) begin
          pend_d = div_val;
          busy_d = 1'b1;
        end
      end
    end

    // Channel state registers with asynchronous reset to the default rate.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        half_q <= RST_HALF;
        pend_q <= RST_HALF;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        half_q <= half_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        busy_q <= busy_d;
      end
    end

    assign clk_out[gi] = clk_q;
    assign tick[gi]    = tick_q;
    assign busy[gi]    = busy_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed scenarios plus random traffic, compared
// every cycle against a countdown-based reference model of each channel.
module tb_clk_divider_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DH  = 4;

  logic           clk_fpga = 1'b0;
  logic           rst_n    = 1'b0;
  logic           en       = 1'b0;
  logic           div_wr   = 1'b0;
  logic [1:0]     div_sel  = '0;
  logic [CW-1:0]  div_val  = '0;
  logic [NCH-1:0] clk_out, tick, busy;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: remaining cycles until the next toggle, level, flags.
  int m_half[NCH];
  int m_pend[NCH];
  int m_rem[NCH];
  bit m_lvl[NCH];
  bit m_tick[NCH];
  bit m_busy[NCH];

  clk_divider_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_HALF(DH)) dut (
    .clk_fpga(clk_fpga),
    .rst_n   (rst_n),
    .en      (en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_half[c] = DH; m_pend[c] = DH; m_rem[c] = DH;
      m_lvl[c] = 1'b0; m_tick[c] = 1'b0; m_busy[c] = 1'b0;
    end
  endtask

  task automatic model_clock(input bit e, input bit w, input int sel, input int val);
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      hit = w && (sel == c);
      m_tick[c] = 1'b0;
      if (m_half[c] == 0) begin
        m_lvl[c] = 1'b0;
        if (hit) begin
          m_half[c] = val; m_pend[c] = val; m_rem[c] = val; m_busy[c] = 1'b0;
        end
      end else begin
        if (e) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_half[c] = m_pend[c];
            m_rem[c]  = m_pend[c];
            m_busy[c] = 1'b0;
            if (m_pend[c] == 0) begin
              m_lvl[c] = 1'b0;
            end else begin
              m_tick[c] = !m_lvl[c];
              m_lvl[c]  = !m_lvl[c];
            end
          end
        end
        if (hit) begin
          m_pend[c] = val; m_busy[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
  endtask

  task automatic check_model(input string tag);
    logic [NCH-1:0] ec, et, eb;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = m_lvl[c]; et[c] = m_tick[c]; eb[c] = m_busy[c];
    end
    chk({tag, ".clk_out"}, clk_out, ec);
    chk({tag, ".tick"}, tick, et);
    chk({tag, ".busy"}, busy, eb);
  endtask

  // One clock cycle: drive inputs, clock DUT and model, compare 1 ns later.
  task automatic step(input string tag, input bit e, input bit w, input int sel, input int val);
    en = e; div_wr = w; div_sel = sel[1:0]; div_val = val[CW-1:0];
    @(posedge clk_fpga);
    model_clock(e, w, sel, val);
    #1;
    check_model(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_fpga);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset.clk_out", clk_out, '0);
    chk("reset.tick", tick, '0);
    chk("reset.busy", busy, '0);
    @(negedge clk_fpga);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #23;
    chk("por.clk_out", clk_out, '0);
    chk("por.tick", tick, '0);
    chk("por.busy", busy, '0);
    @(negedge clk_fpga);
    rst_n = 1'b1;

    // Default rate: first rise after 4 cycles, period 8, tick on rises.
    run("p1", 3);
    chk("p1.pre_rise", clk_out, 3'b000);
    run("p1", 1);
    chk("p1.rise4", clk_out, 3'b111);
    chk("p1.tick4", tick, 3'b111);
    run("p1", 1);
    chk("p1.tick_off", tick, 3'b000);
    run("p1", 3);
    chk("p1.fall8", clk_out, 3'b000);
    run("p1", 4);
    chk("p1.tick12", tick, 3'b111);

    // Mid-period write to channel 1 waits for the boundary.
    run("p2", 2);
    step("p2.wr", 1'b1, 1'b1, 1, 2);
    chk("p2.busy_set", busy, 3'b010);
    run("p2", 12);

    // Stop channel 0, then restart it at half=1.
    step("p3.wr0", 1'b1, 1'b1, 0, 0);
    run("p3", 10);
    chk("p3.stopped", clk_out & 3'b001, 3'b000);
    step("p3.wr1", 1'b1, 1'b1, 0, 1);
    run("p3", 6);

    // Freeze with en low at cnt=2, resume two cycles before the toggle.
    do_reset();
    run("p4", 2);
    for (int i = 0; i < 5; i++) step("p4.hold", 1'b0, 1'b0, 0, 0);
    chk("p4.frozen", clk_out, 3'b000);
    run("p4", 1);
    chk("p4.resume1", clk_out, 3'b000);
    run("p4", 1);
    chk("p4.resume2", clk_out, 3'b111);

    // Write on the exact boundary cycle, then reset mid-period.
    do_reset();
    run("p5", 3);
    step("p5.wr_bnd", 1'b1, 1'b1, 0, 2);
    chk("p5.busy_kept", busy, 3'b001);
    run("p5", 8);
    step("p5.wr1", 1'b1, 1'b1, 1, 5);
    chk("p5.pre_rst_busy", busy, 3'b010);
    do_reset();
    run("p5.after", 16);

    // Out-of-range select is ignored.
    step("p6.wr3", 1'b1, 1'b1, 3, 1);
    chk("p6.busy", busy, 3'b000);
    run("p6", 8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
